dm_ctrl: RTL and testbench

Parametrised data memory with a valid/ready request port and a pulsed response port. It supports byte, halfword and word loads (signed and unsigned) and stores. It detects misaligned and illegal accesses and clears its whole array after reset. It sits in the MEM stage of the pipelined CPU, where the pipeline stalls on req_ready low and waits for rsp_valid.

---
 rtl/dm_ctrl.sv | 156 +++++++++++++++
 tb/tb_dm_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl.sv
// Data memory for the MEM stage: valid/ready request port, one-cycle response pulse,
// byte/half/word loads and stores with alignment checking and a post-reset array clear.
module dm_ctrl #(
  parameter int unsigned ADDR_W        = 12,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);
  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD, S_RESP} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0]      r_mem [DEPTH];
  logic [IDX_W-1:0] r_init_ptr;
  logic             r_init_done;
  logic             r_err;
  logic [31:0]      r_rdata;
  logic [31:0]      r_ld_word;
  logic [1:0]       r_ld_off;
  logic [1:0]       r_ld_size;
  logic             r_ld_uns;

  logic             w_accept;
  logic             w_err;
  logic             w_mem_we;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata_rep;
  logic [7:0]       w_ld_byte;
  logic [15:0]      w_ld_half;
  logic [31:0]      w_ld_result;

  // Request decode: alignment/size check and byte-lane enables for stores.
  always_comb begin
    w_idx       = req_addr[ADDR_W-1:2];
    w_err       = 1'b0;
    w_be        = '0;
    w_wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        w_be        = 4'b0001 << req_addr[1:0];
        w_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_err       = req_addr[0];
        w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        w_err = (req_addr[1:0] != 2'b00);
        w_be  = 4'b1111;
      end
      default: w_err = 1'b1;
    endcase
    w_accept = req_valid && (r_state == S_IDLE);
    w_mem_we = w_accept && req_we && !w_err;
  end

  // Array: INIT sweep or store commit; a reset edge never writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_INIT) begin
        r_mem[r_init_ptr] <= '0;
      end else if (w_mem_we) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !req_we) begin
      r_ld_word <= r_mem[w_idx];
      r_ld_off  <= req_addr[1:0];
      r_ld_size <= req_size;
      r_ld_uns  <= req_unsigned;
    end
  end

  always_comb begin
    case (r_ld_off)
      2'd0:    w_ld_byte = r_ld_word[7:0];
      2'd1:    w_ld_byte = r_ld_word[15:8];
      2'd2:    w_ld_byte = r_ld_word[23:16];
      default: w_ld_byte = r_ld_word[31:24];
    endcase
    w_ld_half = r_ld_off[1] ? r_ld_word[31:16] : r_ld_word[15:0];
    case (r_ld_size)
      2'b00:   w_ld_result = r_ld_uns ? {24'h0, w_ld_byte} : {{24{w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_ld_result = r_ld_uns ? {16'h0, w_ld_half} : {{16{w_ld_half[15]}}, w_ld_half};
      default: w_ld_result = r_ld_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_ptr  <= '0;
      r_init_done <= ~INIT_ON_RESET;
      r_err       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (r_state == S_INIT) begin
        r_init_ptr <= r_init_ptr + 1'b1;
        if (&r_init_ptr) r_init_done <= 1'b1;
      end
      if (w_accept) begin
        r_err <= w_err;
        if (req_we || w_err) r_rdata <= '0;
      end
      if (r_state == S_LOAD) r_rdata <= w_ld_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= INIT_ON_RESET ? S_INIT : S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      S_INIT: if (&r_init_ptr) w_state_nxt = S_IDLE;
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = (req_we || w_err) ? S_RESP : S_LOAD;
      end
      S_LOAD: w_state_nxt = S_RESP;
      default: begin
        rsp_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = (r_state == S_RESP) && r_err;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: directed table, pipelined-load timing, random traffic
// against a byte-array model, and reset-abort behaviour with and without the INIT sweep.
module tb_dm_ctrl;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid0 = 1'b0, valid1 = 1'b0;
  logic          we = 1'b0, uns = 1'b0;
  logic [1:0]    size = 2'b00;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic          sel = 1'b0;

  logic          ready0, rv0, err0, done0;
  logic [31:0]   rdata0;
  logic          ready1, rv1, err1, done1;
  logic [31:0]   rdata1;
  logic          ready_s, rv_s, err_s;
  logic [31:0]   rdata_s;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mdl [1 << AW];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_r;
    logic        exp_e;
    int          lat;
  } vec_t;
  vec_t tbl[$];

  dm_ctrl #(.ADDR_W(AW), .INIT_ON_RESET(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(valid0), .req_ready(ready0), .req_we(we),
    .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv0), .rsp_rdata(rdata0), .rsp_err(err0), .init_done(done0)
  );

  dm_ctrl #(.ADDR_W(AW), .INIT_ON_RESET(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1), .req_we(we),
    .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv1), .rsp_rdata(rdata1), .rsp_err(err1), .init_done(done1)
  );

  always_comb begin
    ready_s = sel ? ready1 : ready0;
    rv_s    = sel ? rv1    : rv0;
    err_s   = sel ? err1   : err0;
    rdata_s = sel ? rdata1 : rdata0;
  end

  initial forever #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic w, logic [1:0] s, logic u, logic [11:0] a, logic [31:0] d,
                              logic [31:0] r, logic e, int l);
    vec_t v;
    v.we = w; v.size = s; v.uns = u; v.addr = a; v.wdata = d;
    v.exp_r = r; v.exp_e = e; v.lat = l;
    return v;
  endfunction

  function automatic void mdl_clear();
    foreach (mdl[i]) mdl[i] = 8'h00;
  endfunction

  // Reference: memory as a flat byte array, loads built and sign-extended arithmetically.
  function automatic void model_access(input logic w, input logic [1:0] s, input logic u,
                                       input logic [AW-1:0] a, input logic [31:0] d,
                                       output logic [31:0] r, output logic e);
    int     n;
    longint v;
    n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    e = (s == 2'd3) || ((int'(a) % n) != 0);
    r = '0;
    if (e) return;
    if (w) begin
      for (int i = 0; i < n; i++) mdl[int'(a) + i] = d[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(mdl[int'(a) + i]) << (8*i));
      if (!u && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
      r = v[31:0];
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h, required %h", nm, act, exp);
    end
  endtask

  // Called and returns at a negedge; checks response value, error, latency, pulse width and hold.
  task automatic do_req(input string nm, input logic w, input logic [1:0] s, input logic u,
                        input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [31:0] exp_r, input logic exp_e, input int exp_lat);
    int          n;
    int          lat;
    logic [31:0] r;
    logic        e;
    we = w; size = s; uns = u; addr = a; wdata = d;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    n = 0;
    while (!ready_s && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ready_s) begin
      miscompares++;
      $display("FAIL %s_accept: ready actual 0 after %0d cycles, required 1", nm, n);
      valid0 = 1'b0; valid1 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    valid0 = 1'b0; valid1 = 1'b0;
    lat = 0; r = '0; e = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (rv_s) begin
        lat = i; r = rdata_s; e = err_s;
        break;
      end
    end
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_rdata"}, r, exp_r);
    chk({nm, "_err"}, e, exp_e);
    @(negedge clk);
    chk({nm, "_pulse_drop"}, rv_s, 1'b0);
    chk({nm, "_err_drop"}, err_s, 1'b0);
    chk({nm, "_rdata_hold"}, rdata_s, exp_r);
  endtask

  // Accept an LBU @0x040 and assert reset while it sits in LOAD.
  task automatic abort_load();
    chk("abort_ready", ready_s, 1'b1);
    we = 1'b0; size = 2'd0; uns = 1'b1; addr = 12'h040;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    @(posedge clk);
    #1;
    valid0 = 1'b0; valid1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_no_rsp_load", rv_s, 1'b0);
    @(negedge clk);
    chk("abort_no_rsp_rst", rv_s, 1'b0);
    rst = 1'b0;
  endtask

  task automatic wait_init(input string nm);
    int n, early, pulses;
    n = 0; early = 0; pulses = 0;
    while (!ready0 && n < 3000) begin
      if (done0) early++;
      if (rv0) pulses++;
      n++;
      @(negedge clk);
    end
    chk({nm, "_cycles"}, n, 1024);
    chk({nm, "_done_set"}, done0, 1'b1);
    chk({nm, "_done_early"}, early, 0);
    chk({nm, "_no_pulse"}, pulses, 0);
  endtask

  initial begin
    logic [31:0] er;
    logic        ee;
    logic        w, u;
    logic [1:0]  s;
    logic [AW-1:0] a;
    logic [31:0] d;
    int          acc[$];
    int          pulses;

    // Reset state of both flavours.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready0, 1'b0);
    chk("rst_valid", rv0, 1'b0);
    chk("rst_rdata", rdata0, 32'h0);
    chk("rst_err", err0, 1'b0);
    chk("rst_init_done", done0, 1'b0);
    chk("rst_noinit_done", done1, 1'b1);
    chk("rst_noinit_ready", ready1, 1'b1);
    rst = 1'b0;
    wait_init("init");
    mdl_clear();

    do_req("lw_3fc", 1'b0, 2'd2, 1'b0, 12'h3FC, 32'h0, 32'h0, 1'b0, 2);

    tbl.push_back(mk(1, 2, 0, 12'h010, 32'h80F17F02, 32'h00000000, 0, 1));
    tbl.push_back(mk(0, 0, 0, 12'h010, 32'h0,        32'h00000002, 0, 2));
    tbl.push_back(mk(0, 0, 0, 12'h011, 32'h0,        32'h0000007F, 0, 2));
    tbl.push_back(mk(0, 0, 0, 12'h012, 32'h0,        32'hFFFFFFF1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 12'h013, 32'h0,        32'hFFFFFF80, 0, 2));
    tbl.push_back(mk(0, 0, 1, 12'h012, 32'h0,        32'h000000F1, 0, 2));
    tbl.push_back(mk(1, 2, 0, 12'h020, 32'h11223344, 32'h00000000, 0, 1));
    tbl.push_back(mk(1, 1, 0, 12'h022, 32'h5A5ABEEF, 32'h00000000, 0, 1));
    tbl.push_back(mk(0, 2, 0, 12'h020, 32'h0,        32'hBEEF3344, 0, 2));
    tbl.push_back(mk(0, 1, 0, 12'h022, 32'h0,        32'hFFFFBEEF, 0, 2));
    tbl.push_back(mk(0, 1, 1, 12'h022, 32'h0,        32'h0000BEEF, 0, 2));
    tbl.push_back(mk(1, 2, 0, 12'h000, 32'h01020304, 32'h00000000, 0, 1));
    tbl.push_back(mk(1, 2, 0, 12'h004, 32'hCAFEBABE, 32'h00000000, 0, 1));
    tbl.push_back(mk(1, 2, 0, 12'h005, 32'h12345678, 32'h00000000, 1, 1));
    tbl.push_back(mk(1, 1, 0, 12'h003, 32'h0000FFFF, 32'h00000000, 1, 1));
    tbl.push_back(mk(0, 3, 0, 12'h000, 32'h0,        32'h00000000, 1, 1));
    tbl.push_back(mk(1, 3, 0, 12'h000, 32'hDEADBEEF, 32'h00000000, 1, 1));
    tbl.push_back(mk(0, 2, 0, 12'h004, 32'h0,        32'hCAFEBABE, 0, 2));
    tbl.push_back(mk(0, 2, 0, 12'h000, 32'h0,        32'h01020304, 0, 2));
    tbl.push_back(mk(0, 2, 0, 12'h006, 32'h0,        32'h00000000, 1, 1));
    tbl.push_back(mk(1, 0, 0, 12'h007, 32'h123456A5, 32'h00000000, 0, 1));
    tbl.push_back(mk(0, 0, 1, 12'h007, 32'h0,        32'h000000A5, 0, 2));
    tbl.push_back(mk(0, 2, 1, 12'h004, 32'h0,        32'hA5FEBABE, 0, 2));
    tbl.push_back(mk(1, 1, 0, 12'h024, 32'hFFFF1234, 32'h00000000, 0, 1));
    tbl.push_back(mk(0, 2, 0, 12'h024, 32'h0,        32'h00001234, 0, 2));
    foreach (tbl[i]) begin
      model_access(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, er, ee);
      do_req($sformatf("tbl%0d", i), tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
             tbl[i].wdata, tbl[i].exp_r, tbl[i].exp_e, tbl[i].lat);
    end

    // Back-to-back loads with req_valid held high.
    model_access(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, er, ee);
    we = 1'b0; size = 2'd2; uns = 1'b0; addr = 12'h010;
    valid0 = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (ready0) acc.push_back(k);
      if (rv0) begin
        pulses++;
        chk("b2b_rdata", rdata0, er);
      end
      @(negedge clk);
    end
    valid0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rv0) pulses++;
      @(negedge clk);
    end
    chk("b2b_accepts", acc.size(), 4);
    for (int i = 1; i < acc.size(); i++) chk("b2b_spacing", acc[i] - acc[i-1], 3);
    chk("b2b_pulses", pulses, 4);

    // Random traffic over a small window so loads hit earlier stores.
    for (int k = 0; k < 150; k++) begin
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      u = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 255));
      d = $urandom;
      model_access(w, s, u, a, d, er, ee);
      do_req($sformatf("rand%0d", k), w, s, u, a, d, er, ee, (w || ee) ? 2'd1 : 2'd2);
    end

    // Reset during LOAD with INIT sweep: no response, array cleared.
    do_req("sb_040", 1'b1, 2'd0, 1'b0, 12'h040, 32'h000000AA, 32'h0, 1'b0, 1);
    abort_load();
    chk("abort_init_ready", ready0, 1'b0);
    chk("abort_init_done", done0, 1'b0);
    wait_init("reinit");
    mdl_clear();
    do_req("lbu_040_cleared", 1'b0, 2'd0, 1'b1, 12'h040, 32'h0, 32'h0, 1'b0, 2);

    // Same abort without INIT sweep: committed store survives.
    sel = 1'b1;
    do_req("noinit_sb_040", 1'b1, 2'd0, 1'b0, 12'h040, 32'h000000AA, 32'h0, 1'b0, 1);
    abort_load();
    chk("noinit_abort_ready", ready1, 1'b1);
    chk("noinit_abort_done", done1, 1'b1);
    do_req("noinit_lbu_040", 1'b0, 2'd0, 1'b1, 12'h040, 32'h0, 32'h000000AA, 1'b0, 2);
    do_req("noinit_lb_040", 1'b0, 2'd0, 1'b0, 12'h040, 32'h0, 32'hFFFFFFAA, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
